// File: rtl/sr_bank.sv
// Bank of WIDTH clocked set/reset latches with selectable conflict priority,
// optional edge-triggered set, synchronous clear, transition pulses and popcount.
module sr_bank #(
   parameter int unsigned     WIDTH    = 8,
   parameter int unsigned     RESETS   = 2,
   parameter int unsigned     PRIORITY = 0,
   parameter int unsigned     EDGE     = 0,
   parameter logic [WIDTH-1:0] INIT    = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             s,
   input  logic [WIDTH*RESETS-1:0]      r,
   input  logic                         clr,
   output logic [WIDTH-1:0]             q,
   output logic [WIDTH-1:0]             q_bar,
   output logic [WIDTH-1:0]             rose,
   output logic [WIDTH-1:0]             fell,
   output logic [$clog2(WIDTH+1)-1:0]   count,
   output logic                         any
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         n = n + CW'(v[i]);
      end
      return n;
   endfunction

   localparam logic [CW-1:0] INIT_COUNT = popcnt(INIT);

   logic [WIDTH-1:0] s_prev;
   logic [WIDTH-1:0] r_int;
   logic [WIDTH-1:0] set_eff;
   logic [WIDTH-1:0] q_next;

   always_comb begin
      r_int = '0;
      for (int c = 0; c < int'(WIDTH); c++) begin
         for (int k = 0; k < int'(RESETS); k++) begin
            r_int[c] = r_int[c] | r[c + int'(WIDTH) * k];
         end
      end
   end

   // s_prev starts at 0 after reset, so s already high on the first edge counts as a rise
   assign set_eff = (EDGE != 0) ? (s & ~s_prev) : s;

   always_comb begin
      q_next = q;
      for (int c = 0; c < int'(WIDTH); c++) begin
         if (clr) begin
            q_next[c] = 1'b0;
         end else begin
            case ({set_eff[c], r_int[c]})
               2'b10:   q_next[c] = 1'b1;
               2'b01:   q_next[c] = 1'b0;
               2'b11: begin
                  case (PRIORITY)
                     1:       q_next[c] = 1'b1;
                     2:       q_next[c] = 1'b0;
                     3:       q_next[c] = ~q[c];
                     default: q_next[c] = q[c];
                  endcase
               end
               default: q_next[c] = q[c];
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q      <= INIT;
         rose   <= '0;
         fell   <= '0;
         count  <= INIT_COUNT;
         any    <= |INIT;
         s_prev <= '0;
      end else begin
         q      <= q_next;
         rose   <= ~q & q_next;
         fell   <= q & ~q_next;
         count  <= popcnt(q_next);
         any    <= |q_next;
         s_prev <= s;
      end
   end

   assign q_bar = ~q;

endmodule
